// File: rtl/lc4_pkg.sv
// LC4 opcode map, link register and the per-lane decode bundle.
package lc4_pkg;

    localparam logic [3:0] BR      = 4'b0000;
    localparam logic [3:0] ARITH   = 4'b0001;
    localparam logic [3:0] CMP     = 4'b0010;
    localparam logic [3:0] JSR     = 4'b0100;
    localparam logic [3:0] LOGIC   = 4'b0101;
    localparam logic [3:0] LDR     = 4'b0110;
    localparam logic [3:0] STR     = 4'b0111;
    localparam logic [3:0] RTI     = 4'b1000;
    localparam logic [3:0] CONST   = 4'b1001;
    localparam logic [3:0] SHIFT   = 4'b1010;
    localparam logic [3:0] JMP     = 4'b1100;
    localparam logic [3:0] HICONST = 4'b1101;
    localparam logic [3:0] TRAP    = 4'b1111;

    localparam int         SEL_W = 3;
    localparam logic [2:0] R7    = 3'd7;

    typedef struct packed {
        logic [SEL_W-1:0] r1sel;
        logic [SEL_W-1:0] r2sel;
        logic [SEL_W-1:0] wsel;
        logic             r1re;
        logic             r2re;
        logic             we;
        logic             nzp_we;
        logic             pc_plus_one;
        logic             is_load;
        logic             is_store;
        logic             is_branch;
        logic             is_control;
        logic             illegal;
    } lane_dec_t;

endpackage

// File: rtl/lc4_decode_stage_nway_if.sv
// Fetch-group in / issue-packet out bundle of the N-way decode stage.
// out_illegal exists only with LC4_DECODE_ILLEGAL_EN.
interface lc4_decode_stage_nway_if #(
    parameter int WAYS = 2,
    parameter int PC_W = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [16*WAYS-1:0]   in_insn;
    logic [WAYS-1:0]      in_lane_valid;
    logic [PC_W-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [WAYS-1:0]      out_lane_valid;
    logic [16*WAYS-1:0]   out_insn;
    logic [PC_W*WAYS-1:0] out_pc;
    logic [3*WAYS-1:0]    out_r1sel;
    logic [3*WAYS-1:0]    out_r2sel;
    logic [3*WAYS-1:0]    out_wsel;
    logic [WAYS-1:0]      out_r1re;
    logic [WAYS-1:0]      out_r2re;
    logic [WAYS-1:0]      out_regfile_we;
    logic [WAYS-1:0]      out_nzp_we;
    logic [WAYS-1:0]      out_select_pc_plus_one;
    logic [WAYS-1:0]      out_is_load;
    logic [WAYS-1:0]      out_is_store;
    logic [WAYS-1:0]      out_is_branch;
    logic [WAYS-1:0]      out_is_control_insn;
`ifdef LC4_DECODE_ILLEGAL_EN
    logic [WAYS-1:0]      out_illegal;
`endif

    modport master (
        output flush, in_valid, in_insn, in_lane_valid, in_pc,
        output out_ready,
        input  in_ready, out_valid, out_lane_valid, out_insn, out_pc,
        input  out_r1sel, out_r2sel, out_wsel, out_r1re, out_r2re,
        input  out_regfile_we, out_nzp_we, out_select_pc_plus_one,
        input  out_is_load, out_is_store, out_is_branch,
        input  out_is_control_insn
`ifdef LC4_DECODE_ILLEGAL_EN
        , input out_illegal
`endif
    );

    modport slave (
        input  flush, in_valid, in_insn, in_lane_valid, in_pc,
        input  out_ready,
        output in_ready, out_valid, out_lane_valid, out_insn, out_pc,
        output out_r1sel, out_r2sel, out_wsel, out_r1re, out_r2re,
        output out_regfile_we, out_nzp_we, out_select_pc_plus_one,
        output out_is_load, out_is_store, out_is_branch,
        output out_is_control_insn
`ifdef LC4_DECODE_ILLEGAL_EN
        , output out_illegal
`endif
    );

endinterface

// File: rtl/lc4_decode_lane.sv
// Combinational single-instruction LC4 decoder.
// LC4_DECODE_ILLEGAL_EN flags unassigned opcodes as illegal.
module lc4_decode_lane
    import lc4_pkg::*;
(
    input  logic [15:0] insn,
    output lane_dec_t   dec
);
    logic [3:0] op;
    logic [2:0] ra, rb, rc;

    assign op = insn[15:12];
    assign ra = insn[11:9];
    assign rb = insn[8:6];
    assign rc = insn[2:0];

    always_comb begin
        dec = '0;
        unique case (op)
            // nzp field of zero is the NOP encoding
            BR: dec.is_branch = |ra;
            ARITH, LOGIC: begin
                dec.r1sel  = rb;
                dec.r1re   = 1'b1;
                dec.r2sel  = rc;
                dec.r2re   = !insn[5] &&
                             !(op == LOGIC && insn[4:3] == 2'b01);
                dec.wsel   = ra;
                dec.we     = 1'b1;
                dec.nzp_we = 1'b1;
            end
            CMP: begin
                dec.r1sel  = ra;
                dec.r1re   = 1'b1;
                dec.r2sel  = rc;
                dec.r2re   = !insn[8];
                dec.nzp_we = 1'b1;
            end
            JSR: begin
                dec.r1sel       = rb;
                dec.r1re        = !insn[11];
                dec.wsel        = R7;
                dec.we          = 1'b1;
                dec.nzp_we      = 1'b1;
                dec.pc_plus_one = 1'b1;
                dec.is_control  = 1'b1;
            end
            LDR: begin
                dec.r1sel   = rb;
                dec.r1re    = 1'b1;
                dec.wsel    = ra;
                dec.we      = 1'b1;
                dec.nzp_we  = 1'b1;
                dec.is_load = 1'b1;
            end
            STR: begin
                dec.r1sel    = rb;
                dec.r1re     = 1'b1;
                dec.r2sel    = ra;
                dec.r2re     = 1'b1;
                dec.is_store = 1'b1;
            end
            RTI: begin
                dec.r1sel      = R7;
                dec.r1re       = 1'b1;
                dec.is_control = 1'b1;
            end
            CONST: begin
                dec.wsel   = ra;
                dec.we     = 1'b1;
                dec.nzp_we = 1'b1;
            end
            SHIFT: begin
                dec.r1sel  = rb;
                dec.r1re   = 1'b1;
                dec.r2sel  = rc;
                dec.r2re   = insn[5:4] == 2'b11;
                dec.wsel   = ra;
                dec.we     = 1'b1;
                dec.nzp_we = 1'b1;
            end
            JMP: begin
                dec.r1sel      = rb;
                dec.r1re       = !insn[11];
                dec.is_control = 1'b1;
            end
            HICONST: begin
                dec.r1sel  = ra;
                dec.r1re   = 1'b1;
                dec.wsel   = ra;
                dec.we     = 1'b1;
                dec.nzp_we = 1'b1;
            end
            TRAP: begin
                dec.wsel        = R7;
                dec.we          = 1'b1;
                dec.nzp_we      = 1'b1;
                dec.pc_plus_one = 1'b1;
                dec.is_control  = 1'b1;
            end
            default: begin
`ifdef LC4_DECODE_ILLEGAL_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/lc4_decode_stage_nway.sv
// N-way LC4 decode stage: buffers a fetch group, issues hazard-free
// in-order packets. LC4_DECODE_ILLEGAL_EN adds out_illegal.
module lc4_decode_stage_nway
    import lc4_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int PC_W = 16
) (
    input logic clk,
    input logic rst_n,
    lc4_decode_stage_nway_if.slave io
);
    typedef enum logic {EMPTY, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WAYS-1:0]    rem_q, rem_d;
    logic [16*WAYS-1:0] insn_q, insn_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    lane_dec_t       dec [WAYS];
    logic [WAYS-1:0] pkt;
    logic [7:0]      wr_acc;
    logic            nzp_acc, mem_acc, started, stop;
    logic            hold, last, take;

    assign hold         = state_q == HOLD;
    assign last         = (rem_q & ~pkt) == '0;
    assign io.out_valid = hold;
    assign io.in_ready  = !hold || (io.out_ready && last);

    // Grow the packet from the lowest remaining lane until a conflict
    // with lanes already in it, a gap, or a packet-ending lane.
    always_comb begin
        pkt     = '0;
        wr_acc  = '0;
        nzp_acc = 1'b0;
        mem_acc = 1'b0;
        started = 1'b0;
        stop    = 1'b0;
        for (int k = 0; k < WAYS; k++) begin
            if (!stop) begin
                if (rem_q[k]) begin
                    if ((dec[k].r1re && wr_acc[dec[k].r1sel]) ||
                        (dec[k].r2re && wr_acc[dec[k].r2sel]) ||
                        (dec[k].we && wr_acc[dec[k].wsel]) ||
                        (dec[k].is_branch && nzp_acc) ||
                        ((dec[k].is_load || dec[k].is_store) &&
                         mem_acc)) begin
                        stop = 1'b1;
                    end else begin
                        pkt[k]  = 1'b1;
                        started = 1'b1;
                        if (dec[k].we) wr_acc[dec[k].wsel] = 1'b1;
                        nzp_acc = nzp_acc | dec[k].nzp_we;
                        mem_acc = mem_acc | dec[k].is_load |
                                  dec[k].is_store;
                        stop    = dec[k].is_branch |
                                  dec[k].is_control | dec[k].illegal;
                    end
                end else if (started) begin
                    stop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
        take    = 1'b0;
        if (io.flush) begin
            state_d = EMPTY;
            rem_d   = '0;
        end else begin
            if (hold && io.out_ready) rem_d = rem_q & ~pkt;
            if (rem_d == '0) begin
                state_d = EMPTY;
                take    = io.in_valid && (|io.in_lane_valid);
            end
            if (take) begin
                state_d = HOLD;
                rem_d   = io.in_lane_valid;
                insn_d  = io.in_insn;
                pc_d    = io.in_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rem_q   <= '0;
            insn_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
        end
    end

    assign io.out_lane_valid = pkt;
    assign io.out_insn       = hold ? insn_q : '0;

    for (genvar k = 0; k < WAYS; k++) begin : g_lane
        lc4_decode_lane u_dec (
            .insn (insn_q[16*k +: 16]),
            .dec  (dec[k])
        );

        assign io.out_pc[PC_W*k +: PC_W] =
            hold ? pc_q + PC_W'(k) : '0;
        assign io.out_r1sel[3*k +: 3] = pkt[k] ? dec[k].r1sel : 3'd0;
        assign io.out_r2sel[3*k +: 3] = pkt[k] ? dec[k].r2sel : 3'd0;
        assign io.out_wsel[3*k +: 3]  = pkt[k] ? dec[k].wsel : 3'd0;

        assign io.out_r1re[k]       = pkt[k] & dec[k].r1re;
        assign io.out_r2re[k]       = pkt[k] & dec[k].r2re;
        assign io.out_regfile_we[k] = pkt[k] & dec[k].we;
        assign io.out_nzp_we[k]     = pkt[k] & dec[k].nzp_we;
        assign io.out_select_pc_plus_one[k] =
            pkt[k] & dec[k].pc_plus_one;
        assign io.out_is_load[k]    = pkt[k] & dec[k].is_load;
        assign io.out_is_store[k]   = pkt[k] & dec[k].is_store;
        assign io.out_is_branch[k]  = pkt[k] & dec[k].is_branch;
        assign io.out_is_control_insn[k] =
            pkt[k] & dec[k].is_control;
`ifdef LC4_DECODE_ILLEGAL_EN
        assign io.out_illegal[k]    = pkt[k] & dec[k].illegal;
`endif
    end

endmodule
